// File: rtl/ife_block_issuer_if.sv
// Block capture and issue-bundle bus between the dependence checker,
// the block issuer and the downstream issue consumer.
interface ife_block_issuer_if #(
   parameter int INSTR_WIDTH = 32,
   parameter int BLOCK_SIZE  = 4
);
   logic                                   blk_valid_i;
   logic                                   blk_ready_o;
   logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] blk_instrs_i;
   logic [BLOCK_SIZE-1:0]                  blk_mask_i;
   logic                                   blk_safe_i;
   logic [BLOCK_SIZE-1:0]                  iss_valid_o;
   logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] iss_instrs_o;
   logic                                   iss_parallel_o;
   logic                                   iss_ready_i;

   // Issuer side
   modport slave (
      input  blk_valid_i, blk_instrs_i, blk_mask_i, blk_safe_i, iss_ready_i,
      output blk_ready_o, iss_valid_o, iss_instrs_o, iss_parallel_o
   );

   // Producer/consumer side
   modport master (
      output blk_valid_i, blk_instrs_i, blk_mask_i, blk_safe_i, iss_ready_i,
      input  blk_ready_o, iss_valid_o, iss_instrs_o, iss_parallel_o
   );
endinterface

// File: rtl/ife_block_issuer.sv
// Block issuer: captures one checked block, then issues it either as a single
// parallel bundle (safe) or one instruction per beat on lane 0 (unsafe).
// Keeps saturating counts of completed parallel and serial blocks.
module ife_block_issuer #(
   parameter int INSTR_WIDTH = 32,
   parameter int BLOCK_SIZE  = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ife_block_issuer_if.slave    bus,
   input  logic                 flush_i,
   output logic [CNT_WIDTH-1:0] par_cnt_o,
   output logic [CNT_WIDTH-1:0] ser_cnt_o
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAR = 2'd1, S_SER = 2'd2} state_e;

   localparam logic [BLOCK_SIZE-1:0] LANE0   = BLOCK_SIZE'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

   state_e                                 state_q, state_d;
   logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] instrs_q, instrs_d;
   logic [BLOCK_SIZE-1:0]                  pend_q, pend_d;
   logic [BLOCK_SIZE-1:0]                  iss_valid_q, iss_valid_d;
   logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] iss_instrs_q, iss_instrs_d;
   logic                                   iss_par_q, iss_par_d;
   logic [CNT_WIDTH-1:0]                   par_cnt_q, par_cnt_d;
   logic [CNT_WIDTH-1:0]                   ser_cnt_q, ser_cnt_d;

   logic                                   blk_hs;
   logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] par_lanes;
   logic [BLOCK_SIZE-1:0]                  pend_rest;

   // Isolate the lowest set bit (next slot in program order).
   function automatic logic [BLOCK_SIZE-1:0] lowbit(input logic [BLOCK_SIZE-1:0] m);
      return m & (~m + 1'b1);
   endfunction

   // One-hot mux over the block's slots.
   function automatic logic [INSTR_WIDTH-1:0] pick(
      input logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] v,
      input logic [BLOCK_SIZE-1:0]                  oh
   );
      logic [INSTR_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         if (oh[i]) r = r | v[i];
      end
      return r;
   endfunction

   // Ready is a pure state decode, gated by flush so a flush cycle never captures.
   assign bus.blk_ready_o    = (state_q == S_IDLE) && !flush_i;
   assign blk_hs             = bus.blk_valid_i && bus.blk_ready_o;
   assign pend_rest          = pend_q & ~lowbit(pend_q);

   assign bus.iss_valid_o    = iss_valid_q;
   assign bus.iss_instrs_o   = iss_instrs_q;
   assign bus.iss_parallel_o = iss_par_q;
   assign par_cnt_o          = par_cnt_q;
   assign ser_cnt_o          = ser_cnt_q;

   // Parallel bundle: invalid lanes are forced to zero.
   genvar gi;
   generate
      for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_lane
         assign par_lanes[gi] = bus.blk_mask_i[gi] ? bus.blk_instrs_i[gi] : '0;
      end
   endgenerate

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         instrs_q     <= '0;
         pend_q       <= '0;
         iss_valid_q  <= '0;
         iss_instrs_q <= '0;
         iss_par_q    <= 1'b0;
         par_cnt_q    <= '0;
         ser_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         instrs_q     <= instrs_d;
         pend_q       <= pend_d;
         iss_valid_q  <= iss_valid_d;
         iss_instrs_q <= iss_instrs_d;
         iss_par_q    <= iss_par_d;
         par_cnt_q    <= par_cnt_d;
         ser_cnt_q    <= ser_cnt_d;
      end
   end

   // Next-state selection; flush wins from every state.
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (blk_hs && (|bus.blk_mask_i))
                       state_d = bus.blk_safe_i ? S_PAR : S_SER;
            S_PAR:  if (bus.iss_ready_i) state_d = S_IDLE;
            S_SER:  if (bus.iss_ready_i && (pend_rest == '0)) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Next values of the issue beat, holding registers and counters.
   always_comb begin
      instrs_d     = instrs_q;
      pend_d       = pend_q;
      iss_valid_d  = iss_valid_q;
      iss_instrs_d = iss_instrs_q;
      iss_par_d    = iss_par_q;
      par_cnt_d    = par_cnt_q;
      ser_cnt_d    = ser_cnt_q;
      if (flush_i) begin
         instrs_d     = '0;
         pend_d       = '0;
         iss_valid_d  = '0;
         iss_instrs_d = '0;
         iss_par_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Zero-mask blocks are accepted and simply dropped.
               if (blk_hs && (|bus.blk_mask_i)) begin
                  instrs_d = bus.blk_instrs_i;
                  if (bus.blk_safe_i) begin
                     pend_d       = '0;
                     iss_valid_d  = bus.blk_mask_i;
                     iss_instrs_d = par_lanes;
                     iss_par_d    = 1'b1;
                  end else begin
                     pend_d          = bus.blk_mask_i;
                     iss_valid_d     = LANE0;
                     iss_instrs_d    = '0;
                     iss_instrs_d[0] = pick(bus.blk_instrs_i, lowbit(bus.blk_mask_i));
                     iss_par_d       = 1'b0;
                  end
               end
            end
            S_PAR: begin
               if (bus.iss_ready_i) begin
                  instrs_d     = '0;
                  iss_valid_d  = '0;
                  iss_instrs_d = '0;
                  iss_par_d    = 1'b0;
                  if (par_cnt_q != CNT_MAX) par_cnt_d = par_cnt_q + 1'b1;
               end
            end
            S_SER: begin
               if (bus.iss_ready_i) begin
                  pend_d = pend_rest;
                  if (pend_rest == '0) begin
                     instrs_d     = '0;
                     iss_valid_d  = '0;
                     iss_instrs_d = '0;
                     if (ser_cnt_q != CNT_MAX) ser_cnt_d = ser_cnt_q + 1'b1;
                  end else begin
                     iss_instrs_d[0] = pick(instrs_q, lowbit(pend_rest));
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ife_block_issuer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-of-beats reference model.
module tb_ife_block_issuer;

   localparam int IW   = 32;
   localparam int BS   = 4;
   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   typedef logic [BS-1:0][IW-1:0] blk_t;
   typedef struct packed {
      logic [BS-1:0] v;
      blk_t          ins;
      logic          par;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush_i;
   logic [CW-1:0] par_cnt_o, ser_cnt_o;

   ife_block_issuer_if #(.INSTR_WIDTH(IW), .BLOCK_SIZE(BS)) bus ();

   ife_block_issuer #(.INSTR_WIDTH(IW), .BLOCK_SIZE(BS), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .flush_i   (flush_i),
      .par_cnt_o (par_cnt_o),
      .ser_cnt_o (ser_cnt_o)
   );

   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t beats[$];
   int    m_par = 0;
   int    m_ser = 0;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs();
      beat_t e;
      e = (beats.size() != 0) ? beats[0] : '0;
      chk("iss_valid",  160'(bus.iss_valid_o),    160'(e.v));
      chk("iss_instrs", 160'(bus.iss_instrs_o),   160'(e.ins));
      chk("iss_par",    160'(bus.iss_parallel_o), 160'(e.par));
      chk("par_cnt",    160'(par_cnt_o),          160'(m_par));
      chk("ser_cnt",    160'(ser_cnt_o),          160'(m_ser));
   endtask

   // Reference: a captured block becomes a list of beats; an accepted beat is
   // popped, and popping the last one completes the block.
   task automatic model_edge(input logic bv, input blk_t ins, input logic [BS-1:0] m,
                             input logic safe, input logic fl, input logic rdy);
      beat_t b;
      if (fl) begin
         beats.delete();
      end else if (beats.size() != 0) begin
         if (rdy) begin
            b = beats.pop_front();
            if (beats.size() == 0) begin
               if (b.par) m_par = (m_par < CMAX) ? m_par + 1 : CMAX;
               else       m_ser = (m_ser < CMAX) ? m_ser + 1 : CMAX;
            end
         end
      end else if (bv && m != 0) begin
         if (safe) begin
            b = '0;
            b.v = m;
            b.par = 1'b1;
            for (int i = 0; i < BS; i++) if (m[i]) b.ins[i] = ins[i];
            beats.push_back(b);
         end else begin
            for (int i = 0; i < BS; i++) begin
               if (m[i]) begin
                  b = '0;
                  b.v = 4'b0001;
                  b.ins[0] = ins[i];
                  beats.push_back(b);
               end
            end
         end
      end
   endtask

   // One cycle: drive at the falling edge, check ready, clock, check outputs.
   task automatic step(input logic bv, input blk_t ins, input logic [BS-1:0] m,
                       input logic safe, input logic fl, input logic rdy);
      bus.blk_valid_i  = bv;
      bus.blk_instrs_i = ins;
      bus.blk_mask_i   = m;
      bus.blk_safe_i   = safe;
      bus.iss_ready_i  = rdy;
      flush_i          = fl;
      #1;
      chk("blk_ready", 160'(bus.blk_ready_o), 160'((beats.size() == 0) && !fl));
      @(posedge clk);
      model_edge(bv, ins, m, safe, fl, rdy);
      @(negedge clk);
      check_outputs();
   endtask

   blk_t abcd, rnd;

   initial begin
      abcd = {32'hDDDD_000D, 32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A};
      rst_n = 1'b0;
      flush_i = 1'b0;
      bus.blk_valid_i = 1'b0;
      bus.blk_instrs_i = '0;
      bus.blk_mask_i = '0;
      bus.blk_safe_i = 1'b0;
      bus.iss_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs();
      chk("rst_ready", 160'(bus.blk_ready_o), 160'(1));
      rst_n = 1'b1;

      // Safe 1111 block, then idle
      step(1, abcd, 4'b1111, 1, 0, 1);
      step(0, abcd, 4'b0000, 0, 0, 1);
      step(0, abcd, 4'b0000, 0, 0, 1);
      $display("scenario par_1111 done");

      // Unsafe 1011: A, B, D on lane 0
      step(1, abcd, 4'b1011, 0, 0, 1);
      chk("ser_lane0_A", 160'(bus.iss_instrs_o[0]), 160'(32'hAAAA_000A));
      for (int i = 0; i < 4; i++) step(0, abcd, 4'b0000, 0, 0, 1);
      $display("scenario ser_1011 done");

      // Unsafe 1111 with backpressure on the second beat
      step(1, abcd, 4'b1111, 0, 0, 1);
      step(0, abcd, 4'b0000, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, abcd, 4'b0000, 0, 0, 0);
      chk("ser_hold_B", 160'(bus.iss_instrs_o[0]), 160'(32'hBBBB_000B));
      for (int i = 0; i < 4; i++) step(0, abcd, 4'b0000, 0, 0, 1);
      $display("scenario ser_backpressure done");

      // Flush during the second serial beat, then a normal block
      step(1, abcd, 4'b1111, 0, 0, 1);
      step(0, abcd, 4'b0000, 0, 0, 1);
      step(0, abcd, 4'b0000, 0, 1, 1);
      chk("flush_valid", 160'(bus.iss_valid_o), 160'(0));
      step(1, abcd, 4'b0110, 1, 0, 1);
      step(0, abcd, 4'b0000, 0, 0, 1);
      $display("scenario flush done");

      // Back-to-back empty blocks
      for (int i = 0; i < 5; i++) step(1, abcd, 4'b0000, i[0], 0, 1);
      $display("scenario zero_mask done");

      // Parallel counter saturation
      for (int i = 0; i < 20; i++) step(1, abcd, 4'b0001, 1, 0, 1);
      chk("par_sat", 160'(par_cnt_o), 160'(CMAX));
      $display("scenario par_saturate done");

      // Asynchronous reset in the middle of a PAR beat
      step(1, abcd, 4'b1111, 1, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      beats.delete();
      m_par = 0;
      m_ser = 0;
      check_outputs();
      chk("async_rst_ready", 160'(bus.blk_ready_o), 160'(1));
      @(negedge clk);
      rst_n = 1'b1;
      $display("scenario async_reset done");

      // Random traffic
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < BS; i++) rnd[i] = $urandom;
         step(($urandom_range(99, 0) < 60), rnd, 4'($urandom_range(15, 0)),
              ($urandom_range(1, 0) == 1), ($urandom_range(99, 0) < 4),
              ($urandom_range(99, 0) < 70));
      end
      $display("scenario random done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
